// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the IF-stage SRAM-like fetch port to AXI4 AR/R channels.
// Single-ID, in-order, up to MAX_OUTSTANDING reads in flight.
module inst_axi_bridge #(
   parameter logic [3:0]  ARID_VAL        = 4'd0,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   // IF-stage fetch port
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // AXI AR channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI R channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        bus_err
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_BUSY = 1'b1
   } ar_state_e;

   ar_state_e          r_state;
   ar_state_e          w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_araddr;
   logic [1:0]         r_arsize;
   logic               r_bus_err;

   logic               w_ar_free;
   logic               w_cnt_ok;
   logic               w_accept;
   logic               w_r_hs;
   logic               w_r_done;
   logic               w_unused;

   // Write-side inputs and rid carry no information for an in-order fetch path.
   assign w_unused = ^{inst_sram_wstrb, inst_sram_wdata, rid};

   assign w_ar_free = (r_state == AR_IDLE) | arready;
   assign w_cnt_ok  = (r_cnt < CNT_W'(MAX_OUTSTANDING));
   assign w_accept  = ~reset & inst_sram_req & ~inst_sram_wr & w_cnt_ok & w_ar_free;
   assign w_r_hs    = rvalid & rready;
   assign w_r_done  = w_r_hs & rlast;

   // AR next-state: a new accept refills the slot, an unrefilled handshake empties it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         AR_IDLE: if (w_accept)            w_state_nxt = AR_BUSY;
         AR_BUSY: if (arready && !w_accept) w_state_nxt = AR_IDLE;
         default:                          w_state_nxt = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= AR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // AR payload only moves on accept, so it is stable while arready is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_araddr <= 32'd0;
         r_arsize <= 2'd0;
      end else if (w_accept) begin
         r_araddr <= inst_sram_addr;
         r_arsize <= inst_sram_size;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_accept && !w_r_done) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_accept && w_r_done) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bus_err <= 1'b0;
      end else if (w_r_hs && (rresp != 2'b00)) begin
         r_bus_err <= 1'b1;
      end
   end

   assign inst_sram_addr_ok = w_accept;
   assign inst_sram_data_ok = w_r_hs;
   assign inst_sram_rdata   = rdata;

   assign arid    = ARID_VAL;
   assign araddr  = r_araddr;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, r_arsize};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = (r_state == AR_BUSY);

   assign rready  = (r_cnt != '0);
   assign bus_err = r_bus_err;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: a queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_inst_axi_bridge;

   localparam int MAX = 2;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok, data_ok;
   logic [31:0] srdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready, bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   inst_axi_bridge #(.ARID_VAL(4'd0), .MAX_OUTSTANDING(MAX)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
      .inst_sram_addr(addr), .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
      .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(srdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .bus_err(bus_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: queue of accepted-but-unreturned addresses and one pending AR beat
   logic [31:0] m_q[$];
   logic        m_ar_pend = 1'b0;
   logic [31:0] m_addr    = 32'd0;
   logic [1:0]  m_size    = 2'd0;
   logic        m_err     = 1'b0;
   logic        e_addr_ok, e_rready, e_data_ok;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (reset) begin
            m_q.delete();
            m_ar_pend = 1'b0;
            m_addr    = 32'd0;
            m_size    = 2'd0;
            m_err     = 1'b0;
         end
         e_addr_ok = !reset && req && !wr && (m_q.size() < MAX) && (!m_ar_pend || arready);
         e_rready  = (m_q.size() != 0);
         e_data_ok = rvalid && e_rready;
         chk("m_addr_ok", 32'(addr_ok), 32'(e_addr_ok));
         chk("m_data_ok", 32'(data_ok), 32'(e_data_ok));
         if (e_data_ok) chk("m_rdata", srdata, rdata);
         chk("m_arvalid", 32'(arvalid), 32'(m_ar_pend));
         chk("m_araddr", araddr, m_addr);
         chk("m_arsize", 32'(arsize), 32'({1'b0, m_size}));
         chk("m_rready", 32'(rready), 32'(e_rready));
         chk("m_bus_err", 32'(bus_err), 32'(m_err));
         chk("m_ar_const", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
             {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 9'd0});
         if (!reset) begin
            if (e_data_ok && rresp != 2'b00) m_err = 1'b1;
            if (e_data_ok && rlast) void'(m_q.pop_front());
            if (e_addr_ok) begin
               m_q.push_back(addr);
               m_ar_pend = 1'b1;
               m_addr    = addr;
               m_size    = size;
            end else if (m_ar_pend && arready) begin
               m_ar_pend = 1'b0;
            end
         end
      end
   end

   task automatic idle_inputs();
      req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'd0; arready = 1'b0;
      rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b1;
   endtask

   // One cycle of stimulus; returns 2 time units after the falling edge
   task automatic cyc(input logic i_req, input logic [31:0] i_addr, input logic i_arready,
                      input logic i_rvalid, input logic [31:0] i_rdata, input logic [1:0] i_rresp);
      @(negedge clk);
      req = i_req; wr = 1'b0; size = 2'd2; addr = i_addr; arready = i_arready;
      rvalid = i_rvalid; rdata = i_rdata; rresp = i_rresp; rlast = 1'b1;
      #2;
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
      chk({tag, "_rready"},  32'(rready),  32'd0);
      chk({tag, "_addr_ok"}, 32'(addr_ok), 32'd0);
      chk({tag, "_data_ok"}, 32'(data_ok), 32'd0);
      chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
      repeat (2) @(negedge clk);
      idle_inputs();
      #1 reset = 1'b0;
   endtask

   initial begin
      int g;
      idle_inputs();
      req = 1'b1; wstrb = 4'hF; wdata = 32'hFFFF_FFFF; rid = 4'd3;

      // Power-on reset with a request pending
      repeat (2) @(negedge clk);
      #2;
      chk("por_addr_ok", 32'(addr_ok), 32'd0);
      chk("por_arvalid", 32'(arvalid), 32'd0);
      chk("por_araddr", araddr, 32'd0);
      chk("por_arsize", 32'(arsize), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1 reset = 1'b0;
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("por_rready", 32'(rready), 32'd0);

      // Asynchronous reset between edges while busy with req=1
      cyc(1'b1, 32'h1C00_0100, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("ar0_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b1, 32'h1C00_0104, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("ar0_arvalid", 32'(arvalid), 32'd1);
      chk("ar0_rready", 32'(rready), 32'd1);
      pulse_reset("arst");
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("arst_cnt0", 32'(rready), 32'd0);

      // Single fetch with two cycles of AR backpressure
      cyc(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("sf_addr_ok", 32'(addr_ok), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
         chk("sf_arvalid", 32'(arvalid), 32'd1);
         chk("sf_araddr", araddr, 32'h1C00_0000);
         chk("sf_arsize", 32'(arsize), 32'b010);
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("sf_hs_araddr", araddr, 32'h1C00_0000);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0280_0C0C, 2'b00);
      chk("sf_data_ok", 32'(data_ok), 32'd1);
      chk("sf_rdata", srdata, 32'h0280_0C0C);
      chk("sf_ar_drop", 32'(arvalid), 32'd0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("sf_cnt0", 32'(rready), 32'd0);

      // Back-to-back up to the limit; addr_ok ignores rvalid, so the third request
      // goes in on the cycle after the first R beat frees a slot
      cyc(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb0_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b1, 32'h1C00_0004, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb1_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b1, 32'h1C00_0008, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb2_blocked", 32'(addr_ok), 32'd0);
      chk("bb2_araddr", araddr, 32'h1C00_0004);
      cyc(1'b1, 32'h1C00_0008, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb3_blocked", 32'(addr_ok), 32'd0);
      chk("bb3_ar_idle", 32'(arvalid), 32'd0);
      cyc(1'b1, 32'h1C00_0008, 1'b1, 1'b1, 32'h1111_0000, 2'b00);
      chk("bb4_data_ok", 32'(data_ok), 32'd1);
      chk("bb4_blocked", 32'(addr_ok), 32'd0);
      cyc(1'b1, 32'h1C00_0008, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb5_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("bb6_araddr", araddr, 32'h1C00_0008);
      chk("bb6_rready", 32'(rready), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h2222_0004, 2'b00);
      chk("bb7_data_ok", 32'(data_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h3333_0008, 2'b00);
      chk("bb8_data_ok", 32'(data_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("bb9_cnt0", 32'(rready), 32'd0);

      // Writes are never accepted
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req = 1'b1; wr = 1'b1; addr = 32'h1C00_0F00; arready = 1'b1;
         #2;
         chk("wr_addr_ok", 32'(addr_ok), 32'd0);
         chk("wr_arvalid", 32'(arvalid), 32'd0);
         chk("wr_cnt0", 32'(rready), 32'd0);
      end

      // Error response sets a sticky flag; data_ok still fires
      cyc(1'b1, 32'h1C00_0020, 1'b1, 1'b0, 32'd0, 2'b00);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b10);
      chk("err_data_ok", 32'(data_ok), 32'd1);
      chk("err_pre", 32'(bus_err), 32'd0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("err_set", 32'(bus_err), 32'd1);
      cyc(1'b1, 32'h1C00_0024, 1'b1, 1'b0, 32'd0, 2'b00);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 2'b00);
      chk("err_ok_data_ok", 32'(data_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("err_sticky", 32'(bus_err), 32'd1);

      // Pipelined stream with R returning every cycle
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 32'h1C00_0040 + 32'(4 * i), 1'b1, (i >= 2), 32'hA000_0000 + 32'(i), 2'b00);
         chk("st_addr_ok", 32'(addr_ok), (i == 2) ? 32'd0 : 32'd1);
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      #2;
      g = 0;
      while (m_q.size() != 0 && g < 10) begin
         cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'hB000_0000 + 32'(g), 2'b00);
         #2;
         g++;
      end
      if (g >= 10) begin
         n_checks++;
         n_fail++;
         $display("FAIL st_drain: got %0d cycles, required fewer than 10", g);
      end
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("st_cnt0", 32'(rready), 32'd0);

      // Reset while AR_BUSY with one read outstanding, then a clean fetch
      cyc(1'b1, 32'h1C00_000C, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("rb_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("rb_arvalid", 32'(arvalid), 32'd1);
      chk("rb_cnt1", 32'(rready), 32'd1);
      pulse_reset("rbusy");
      cyc(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("rb2_addr_ok", 32'(addr_ok), 32'd1);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
      chk("rb2_araddr", araddr, 32'h1C00_0010);
      chk("rb2_arvalid", 32'(arvalid), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0340_0000, 2'b00);
      chk("rb2_data_ok", 32'(data_ok), 32'd1);
      chk("rb2_rdata", srdata, 32'h0340_0000);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
      chk("rb2_cnt0", 32'(rready), 32'd0);
      chk("rb2_ar_idle", 32'(arvalid), 32'd0);

      repeat (2) @(negedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
